// File: rtl/change_dispense_controller_if.sv
// Handshake and status bundle between the vend logic / hopper drive (master)
// and the change dispense controller (slave).
// Optional macro: CHANGE_INVENTORY_EN adds the coin_empty tube-status input.
interface change_dispense_controller_if #(
    parameter int AMT_W = 4
);
    logic             start;
    logic [AMT_W-1:0] change_amt;
    logic             hop_ack;
    logic             hop_req;
    logic [1:0]       hop_sel;
    logic             busy;
    logic             done;
    logic             fault;
    logic [AMT_W-1:0] remaining;
    logic [3:0]       coins_paid;
`ifdef CHANGE_INVENTORY_EN
    logic [2:0]       coin_empty;

    modport master (
        output start, change_amt, hop_ack, coin_empty,
        input  hop_req, hop_sel, busy, done, fault, remaining, coins_paid
    );

    modport slave (
        input  start, change_amt, hop_ack, coin_empty,
        output hop_req, hop_sel, busy, done, fault, remaining, coins_paid
    );
`else
    modport master (
        output start, change_amt, hop_ack,
        input  hop_req, hop_sel, busy, done, fault, remaining, coins_paid
    );

    modport slave (
        input  start, change_amt, hop_ack,
        output hop_req, hop_sel, busy, done, fault, remaining, coins_paid
    );
`endif
endinterface

// File: rtl/change_dispense_controller.sv
// Change dispense controller: breaks the change owed into crowns (5),
// florins (2) and shillings (1), largest first, and ejects one coin per
// req/ack handshake with the hopper. A stalled hopper leads to FAULT.
// Optional macro: CHANGE_INVENTORY_EN skips denominations whose tube is
// empty and faults when no usable coin remains.
module change_dispense_controller #(
    parameter int AMT_W       = 4,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int GAP_CYC     = 2_500_000
) (
    input  logic                          clk50,
    input  logic                          reset,
    change_dispense_controller_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE, SELECT, REQ, RELEASE, GAP, DONE, FAULT
    } stateT;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] GAP_LAST     = 32'(GAP_CYC - 1);

    stateT            state;
    stateT            nextState;
    logic [31:0]      timer;
    logic [1:0]       selReg;
    logic [1:0]       pickSel;
    logic [AMT_W-1:0] remainingReg;
    logic [3:0]       coinsPaid;
    logic             timing;

    // Shilling value of a denomination code (3 crown, 2 florin, 1 shilling).
    function automatic logic [AMT_W-1:0] coinValue(input logic [1:0] sel);
        case (sel)
            2'd3:    coinValue = AMT_W'(5);
            2'd2:    coinValue = AMT_W'(2);
            2'd1:    coinValue = AMT_W'(1);
            default: coinValue = '0;
        endcase
    endfunction

    // Pick the largest coin that fits in what is still owed (and is in stock).
    always_comb begin
        pickSel = 2'd0;
`ifdef CHANGE_INVENTORY_EN
        if (remainingReg >= AMT_W'(5) && !bus.coin_empty[2])
            pickSel = 2'd3;
        else if (remainingReg >= AMT_W'(2) && !bus.coin_empty[1])
            pickSel = 2'd2;
        else if (remainingReg >= AMT_W'(1) && !bus.coin_empty[0])
            pickSel = 2'd1;
`else
        if (remainingReg >= AMT_W'(5))
            pickSel = 2'd3;
        else if (remainingReg >= AMT_W'(2))
            pickSel = 2'd2;
        else
            pickSel = 2'd1;
`endif
    end

    // State register; reset abandons any payout in progress.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next-state logic: handshake progress, hopper timeouts and inter-coin gap.
    always_comb begin
        nextState = state;
        case (state)
            IDLE, FAULT: begin
                if (bus.start)
                    nextState = (bus.change_amt == '0) ? DONE : SELECT;
            end
            SELECT:  nextState = (pickSel == 2'd0) ? FAULT : REQ;
            REQ: begin
                if (bus.hop_ack)
                    nextState = RELEASE;
                else if (timer == TIMEOUT_LAST)
                    nextState = FAULT;
            end
            RELEASE: begin
                if (!bus.hop_ack)
                    nextState = GAP;
                else if (timer == TIMEOUT_LAST)
                    nextState = FAULT;
            end
            GAP: begin
                if (timer == GAP_LAST)
                    nextState = (remainingReg == '0) ? DONE : SELECT;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign timing = (state == REQ) || (state == RELEASE) || (state == GAP);

    // Payout bookkeeping and the shared handshake/gap timer, which restarts
    // from zero on every state change.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            remainingReg <= '0;
            coinsPaid    <= '0;
            selReg       <= 2'd0;
            timer        <= '0;
        end else begin
            case (state)
                IDLE, FAULT: begin
                    if (bus.start) begin
                        remainingReg <= bus.change_amt;
                        coinsPaid    <= '0;
                    end
                end
                SELECT: selReg <= pickSel;
                REQ: begin
                    if (bus.hop_ack) begin
                        remainingReg <= remainingReg - coinValue(selReg);
                        if (coinsPaid != 4'hF)
                            coinsPaid <= coinsPaid + 4'd1;
                    end
                end
                default: ;
            endcase
            if (!timing || nextState != state)
                timer <= '0;
            else
                timer <= timer + 32'd1;
        end
    end

    assign bus.hop_req    = (state == REQ);
    assign bus.hop_sel    = (state == REQ || state == RELEASE) ? selReg : 2'd0;
    assign bus.busy       = (state != IDLE) && (state != FAULT);
    assign bus.done       = (state == DONE);
    assign bus.fault      = (state == FAULT);
    assign bus.remaining  = remainingReg;
    assign bus.coins_paid = coinsPaid;

endmodule

// File: doc/change_dispense_controller.md
Name: change_dispense_controller

Overview:
- Sequences the coin-return hopper after a vend and pays out the change owed by the gruel machine.
- Takes a change amount in shillings and breaks it into crowns, florins and shillings, using the largest coin first.
- Issues one hopper request per coin over a req/ack handshake, and flags a fault if the hopper stalls.
- Sits between the vend state logic, which pulses start with the change amount, and the physical hopper drive.

Parameters:
- AMT_W, 4, width of change amount / remaining count in shillings (max 15).
- TIMEOUT_CYC, 50_000_000, clk50 cycles allowed for hop_ack to rise, or to fall, before fault (1 s).
- GAP_CYC, 2_500_000, idle clk50 cycles between successive coin requests (50 ms).

Ports:
- clk50  input  1  on-board 50 MHz clock; all state is rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; latches change_amt and begins payout.
- change_amt  input  AMT_W  change owed in shillings; sampled only when start is high in IDLE or FAULT.
- hop_ack  input  1  hopper acknowledge; high once a coin is ejected, low when the hopper is ready again.
- hop_req  output  1  coin eject request to the hopper.
- hop_sel  output  2  denomination: 0 none, 1 shilling, 2 florin, 3 crown (same code as the coin bus).
- busy  output  1  high in every state except IDLE and FAULT.
- done  output  1  one-cycle pulse when payout completes.
- fault  output  1  high while in FAULT.
- remaining  output  AMT_W  shillings still owed.
- coins_paid  output  4  coins ejected this payout; saturates at 15.

Behaviour:
- Reset (async, active-high): state=IDLE; hop_req=0, hop_sel=0, busy=0, done=0, fault=0, remaining=0, coins_paid=0; timers cleared. hop_req drops immediately, mid-handshake included. No resumption after reset.
- Coin values: crown=5, florin=2, shilling=1.
- Selection, evaluated in SELECT: crown if remaining>=5, else florin if >=2, else shilling.
- IDLE:
  - On start: remaining<=change_amt, coins_paid<=0.
  - Go to DONE if change_amt==0, else SELECT.
- SELECT (1 cycle): register hop_sel per the selection rule, clear timer, go to REQ.
- REQ:
  - hop_req=1 and hop_sel held stable.
  - hop_ack==1: remaining<=remaining-value, coins_paid++ (saturating), hop_req<=0, timer cleared, go to RELEASE.
  - Timer reaches TIMEOUT_CYC with ack low: go to FAULT.
  - Request-to-ack latency is unbounded up to the timeout.
- RELEASE:
  - hop_req=0, hop_sel held.
  - hop_ack==0: go to GAP.
  - Ack still high at TIMEOUT_CYC: go to FAULT.
- GAP:
  - hop_sel=0; count GAP_CYC cycles.
  - Then go to DONE if remaining==0, else SELECT.
- DONE: done=1 for exactly one cycle, hop_sel=0, then IDLE. remaining and coins_paid keep their final values.
- FAULT:
  - hop_req=0, hop_sel=0, fault=1, busy=0; remaining and coins_paid frozen for display.
  - Exit only via reset, or start, which behaves as start in IDLE and clears fault the next cycle.
- Subtraction never underflows, because selection guarantees value<=remaining.
- start while busy=1 is ignored; no queuing.
- hop_ack high in IDLE, SELECT, GAP, DONE or FAULT is ignored.
- Minimum per-coin time is 1 (SELECT) + 1 (REQ) + 1 (RELEASE) + GAP_CYC cycles.
- start and hop_ack in the same cycle: the start rule is applied and ack is ignored, since the block is not in REQ.

Optional Feature:
- Macro: CHANGE_INVENTORY_EN.
- Defined:
  - Adds input coin_empty[2:0]: bit0 shilling, bit1 florin, bit2 crown; high means that tube is empty.
  - SELECT picks the largest coin with value<=remaining whose tube is not empty.
  - If no coin qualifies, go to FAULT with remaining intact.
  - coin_empty is sampled only in SELECT.
- Undefined: the port is absent and selection is pure greedy as above.

Test Plan:
- Reset mid-REQ:
  - Assert reset while hop_req=1 -> hop_req=0 the same cycle, all outputs at reset values.
  - Deassert, then start with change_amt=0 -> done pulse next-next cycle, coins_paid=0.
- Payout of 8:
  - start, change_amt=8, ack bench responds in 3 cycles -> hop_sel sequence 3,2,1.
  - remaining 8->3->1->0; coins_paid=3; one done pulse.
- Payout of 15:
  - start, change_amt=15 -> three crowns, coins_paid=3, done.
  - A start pulse during the payout is ignored: remaining is unaffected.
- Ack timeout:
  - start, change_amt=2, never ack -> fault=1 exactly TIMEOUT_CYC cycles after hop_req rises.
  - remaining=2, hop_req=0.
  - A new start with change_amt=1 recovers and pays one shilling.
- Stuck ack: ack rises and never falls -> FAULT after TIMEOUT_CYC in RELEASE; remaining already decremented.
- CHANGE_INVENTORY_EN: coin_empty=3'b100, change_amt=7 -> hop_sel 2,2,2,1, coins_paid=4.
- CHANGE_INVENTORY_EN, no usable coin: coin_empty=3'b011, change_amt=3 -> immediate FAULT, remaining=3.
